// File: rtl/mem_server.sv
// -----------------------------------------------------------------------------
// mem_server
// Serial-pin memory server. Decodes read16 / write16 commands arriving on
// tx_pins, services them from a small byte-addressed memory, and streams read
// responses back on rx_pins through a FIFO response queue.
//
// Optional feature macro: MEM_SERVER_BYTE_WRITE_EN
//   defined   -> cmd 2'b10 is write8 (16-bit data payload, low byte written)
//   undefined -> cmd 2'b10 is a no-op that only consumes the address
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous active-high reset (memory contents retained)
//   tx_pins    in   [IO_BITS]   command/address/data stream from the CPU
//   rx_pins    out  [IO_BITS]   response stream to the CPU
//   load_en    in   backdoor byte write strobe
//   load_addr  in   [ADDR_BITS] backdoor byte address
//   load_data  in   [8]         backdoor byte data
//   busy       out  RX FSM active or response queue non-empty
//   overflow   out  sticky: a read response was dropped on a full queue
// -----------------------------------------------------------------------------
module mem_server #(
  parameter int unsigned IO_BITS        = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned ADDR_BITS      = 6,
  parameter int unsigned RESP_DEPTH     = 4,
  parameter int unsigned RESP_DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IO_BITS-1:0]   tx_pins,
  output logic [IO_BITS-1:0]   rx_pins,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SR_W     = WORD_W - IO_BITS;
  localparam int unsigned CNT_W    = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
  localparam int unsigned MEM_SIZE = 1 << ADDR_BITS;
  localparam int unsigned PTR_W    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned FCNT_W   = $clog2(RESP_DEPTH + 1);
  localparam int unsigned WAIT_W   = 3;

  localparam logic [1:0] CMD_RD16 = 2'b00;
  localparam logic [1:0] CMD_WR16 = 2'b01;
  localparam logic [1:0] CMD_WR8  = 2'b10;

`ifdef MEM_SERVER_BYTE_WRITE_EN
  localparam bit BYTE_WRITE_EN = 1'b1;
`else
  localparam bit BYTE_WRITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_START, T_DATA} tx_state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  rx_state_e             rx_state_q, rx_state_d;
  tx_state_e             tx_state_q, tx_state_d;

  logic [1:0]            cmd_q, cmd_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;

  logic [7:0]            mem_q [MEM_SIZE];
  logic [7:0]            mem_d [MEM_SIZE];

  logic [WORD_W-1:0]     fifo_q [RESP_DEPTH];
  logic [WORD_W-1:0]     fifo_d [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  overflow_q, overflow_d;

  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      dcnt_q, dcnt_d;
  logic [IO_BITS-1:0]    rx_pins_q, rx_pins_d;
  logic                  busy_q, busy_d;

  logic [WORD_W-1:0]     shift_in;
  logic                  rx_last;
  logic [ADDR_BITS-1:0]  cur_addr;
  logic [ADDR_BITS-1:0]  cur_addr_p1;
  logic [ADDR_BITS-1:0]  addr_p1;
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     head_word;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  wr_lo;
  logic                  wr_hi;
  logic                  tx_last;
  logic                  wait_last;
  logic                  fifo_full;

  // ---------------------------------------------------------------------------
  // Shared payload shifter: each cycle the new group lands in the top bits,
  // so after PAYLOAD_CYCLES groups (LSB group first) shift_in is the word.
  // ---------------------------------------------------------------------------
  assign shift_in    = {tx_pins, sr_q};
  assign rx_last     = (rx_cnt_q == CNT_W'(PAYLOAD_CYCLES - 1));
  assign cur_addr    = shift_in[ADDR_BITS-1:0];
  assign cur_addr_p1 = cur_addr + ADDR_BITS'(1);
  assign addr_p1     = addr_q + ADDR_BITS'(1);
  assign rd_word     = {mem_q[cur_addr_p1], mem_q[cur_addr]};
  assign head_word   = fifo_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // RX FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : rx_state_reg
    if (reset) rx_state_q <= S_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  // RX FSM: next state
  always_comb begin : rx_next
    rx_state_d = rx_state_q;
    case (rx_state_q)
      S_IDLE:  if (tx_pins[0]) rx_state_d = S_CMD;
      S_CMD:   rx_state_d = S_ADDR;
      S_ADDR: begin
        if (rx_last) begin
          if (cmd_q == CMD_WR16 || (BYTE_WRITE_EN && cmd_q == CMD_WR8))
            rx_state_d = S_WDATA;
          else
            rx_state_d = S_IDLE;
        end
      end
      S_WDATA: if (rx_last) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX FSM: datapath controls (command latch, shifter, push, memory write)
  always_comb begin : rx_out
    cmd_d    = cmd_q;
    rx_cnt_d = rx_cnt_q;
    sr_d     = sr_q;
    addr_d   = addr_q;
    push_req = 1'b0;
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    case (rx_state_q)
      S_CMD: begin
        cmd_d    = 2'(tx_pins);
        rx_cnt_d = '0;
      end
      S_ADDR: begin
        sr_d     = shift_in[WORD_W-1:IO_BITS];
        rx_cnt_d = rx_last ? '0 : rx_cnt_q + CNT_W'(1);
        if (rx_last) begin
          addr_d   = cur_addr;
          push_req = (cmd_q == CMD_RD16);
        end
      end
      S_WDATA: begin
        sr_d     = shift_in[WORD_W-1:IO_BITS];
        rx_cnt_d = rx_last ? '0 : rx_cnt_q + CNT_W'(1);
        if (rx_last) begin
          wr_lo = (cmd_q == CMD_WR16) || (BYTE_WRITE_EN && cmd_q == CMD_WR8);
          wr_hi = (cmd_q == CMD_WR16);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory: backdoor load first so a same-byte bus write overrides it.
  // Bus writes are suppressed while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin : mem_next
    mem_d = mem_q;
    if (load_en)          mem_d[load_addr] = load_data;
    if (wr_lo && !reset)  mem_d[addr_q]    = shift_in[7:0];
    if (wr_hi && !reset)  mem_d[addr_p1]   = shift_in[15:8];
  end

  always_ff @(posedge clk) begin : mem_reg
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Response queue. A push while full is accepted only if the head is being
  // popped in the same cycle; otherwise the word is dropped and flagged.
  // ---------------------------------------------------------------------------
  assign fifo_full = (fcnt_q == FCNT_W'(RESP_DEPTH));
  assign push_ok   = push_req && (!fifo_full || pop);

  always_comb begin : fifo_next
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (push_req & ~push_ok);
    fcnt_d     = fcnt_q + FCNT_W'(push_ok) - FCNT_W'(pop);
    if (push_ok) begin
      fifo_d[wr_ptr_q] = rd_word;
      wr_ptr_d = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin : fifo_store_reg
    fifo_q <= fifo_d;
  end

  // ---------------------------------------------------------------------------
  // TX FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : tx_state_reg
    if (reset) tx_state_q <= T_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  assign tx_last   = (dcnt_q == CNT_W'(PAYLOAD_CYCLES - 1));
  assign wait_last = (wait_cnt_q == WAIT_W'(RESP_DELAY - 1));
  assign pop       = (tx_state_q == T_DATA) && tx_last;

  // TX FSM: next state. A push in this cycle counts as queue-available so the
  // start cycle can follow the last address cycle directly.
  always_comb begin : tx_next
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE: begin
        if (fcnt_q != '0 || push_ok)
          tx_state_d = (RESP_DELAY == 0) ? T_START : T_WAIT;
      end
      T_WAIT:  if (wait_last) tx_state_d = T_START;
      T_START: tx_state_d = T_DATA;
      T_DATA:  if (tx_last) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX FSM: outputs, computed from the next state so rx_pins is a flop
  always_comb begin : tx_out
    wait_cnt_d = '0;
    dcnt_d     = '0;
    rx_pins_d  = '0;
    if (tx_state_q == T_WAIT && tx_state_d == T_WAIT)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (tx_state_q == T_DATA && tx_state_d == T_DATA)
      dcnt_d = dcnt_q + CNT_W'(1);
    case (tx_state_d)
      T_START: rx_pins_d = IO_BITS'(1);
      T_DATA:  rx_pins_d = IO_BITS'(head_word >> (IO_BITS * 32'(dcnt_d)));
      default: rx_pins_d = '0;
    endcase
  end

  assign busy_d = (rx_state_d != S_IDLE) || (fcnt_d != '0);

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : dp_reg
    if (reset) begin
      cmd_q      <= '0;
      rx_cnt_q   <= '0;
      sr_q       <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      overflow_q <= 1'b0;
      wait_cnt_q <= '0;
      dcnt_q     <= '0;
      rx_pins_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      rx_cnt_q   <= rx_cnt_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      overflow_q <= overflow_d;
      wait_cnt_q <= wait_cnt_d;
      dcnt_q     <= dcnt_d;
      rx_pins_q  <= rx_pins_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_pins  = rx_pins_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: doc/mem_server.md
MEM_SERVER -- requirements
Module: mem_server

Interface
REQ-001 Parameter IO_BITS, default 2: width of the serial tx_pins and rx_pins buses; bits per transfer cycle.
REQ-002 Parameter PAYLOAD_CYCLES, default 8: cycles per 16-bit address or data payload; equals 16/IO_BITS.
REQ-003 Parameter ADDR_BITS, default 6: byte address width of the internal memory (2^ADDR_BITS bytes).
REQ-004 Parameter RESP_DEPTH, default 4: read-response queue depth; matches the CPU's maximum outstanding reads.
REQ-005 Parameter RESP_DELAY, default 1: extra idle cycles before a response start cycle, range 0..7.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tx_pins  input  IO_BITS  serial command/address/data stream from the CPU.
REQ-009 rx_pins  output  IO_BITS  serial response stream to the CPU.
REQ-010 load_en  input  1  backdoor byte write strobe for bench preload.
REQ-011 load_addr  input  ADDR_BITS  backdoor byte address.
REQ-012 load_data  input  8  backdoor byte data.
REQ-013 busy  output  1  high when the RX FSM is not idle or the response queue is non-empty.
REQ-014 overflow  output  1  sticky flag: a read response was dropped because the queue was full.

Function
REQ-015 RX FSM (decodes tx_pins) states: IDLE, CMD, ADDR, WDATA; in IDLE, tx_pins[0]==1 is a start cycle, go to CMD; otherwise stay.
REQ-016 CMD: latch cmd=tx_pins[1:0]; 2'b00 read16, 2'b01 write16, any other value is a no-op that still consumes the address; go to ADDR.
REQ-017 ADDR: shift in PAYLOAD_CYCLES groups, LSB group first; address bits above ADDR_BITS are discarded.
REQ-018 After the last address cycle: read16 pushes {mem[a+1],mem[a]} into the queue and returns to IDLE; write16 enters WDATA; no-op returns to IDLE.
REQ-019 Byte address a+1 wraps modulo 2^ADDR_BITS.
REQ-020 WDATA: shift in 16 data bits LSB group first; on the last cycle write mem[a]=d[7:0] and mem[a+1]=d[15:8]; return to IDLE.
REQ-021 Read data is sampled at queue push, so a later write to the same address does not alter a queued response.
REQ-022 A start cycle is accepted in the cycle immediately after a transaction's last cycle (back-to-back commands).
REQ-023 TX response FSM states: T_IDLE, T_WAIT, T_START, T_DATA; runs concurrently with the RX FSM.
REQ-024 T_IDLE with non-empty queue: go to T_WAIT for RESP_DELAY cycles (skipped when 0), then T_START.
REQ-025 T_START drives rx_pins=1 for one cycle; T_DATA drives the head word over PAYLOAD_CYCLES cycles, LSB group first, then pops the entry.
REQ-026 rx_pins=0 in every cycle outside T_START and T_DATA.
REQ-027 Minimum latency with RESP_DELAY=0 and an empty queue: start cycle on rx_pins in the cycle after the last address cycle.
REQ-028 A push when the queue is full drops the new word and sets overflow; a push in the same cycle as the final pop is accepted.
REQ-029 Responses are returned in command order (FIFO).
REQ-030 Bus write and load_en to the same byte in the same cycle: the bus write wins.

Reset
REQ-031 On reset: both FSMs idle, queue empty, overflow=0, busy=0, rx_pins=0, shift registers cleared; memory contents are retained.
REQ-032 Reset asserted mid-transaction abandons it with no memory write and no response; the first cycle after reset is an IDLE cycle.

Configuration
REQ-033 With MEM_SERVER_BYTE_WRITE_EN defined, cmd 2'b10 is write8: it takes a full 16-bit WDATA payload and writes only mem[a]=d[7:0].
REQ-034 With MEM_SERVER_BYTE_WRITE_EN undefined, cmd 2'b10 is a no-op (address consumed, no WDATA phase).

Verification
REQ-035 Preload mem[4]=0x34, mem[5]=0x12; read16 of address 4, RESP_DELAY=0 -> rx start in the cycle after the last address cycle, then groups 0,1,3,0,2,0,1,0.
REQ-036 write16 of 0xBEEF to address 0x3F, then read16 of 0x3F -> mem[0x3F]=0xEF, mem[0x00]=0xBE, response 0xBEEF (wrap).
REQ-037 Five back-to-back read16 of addresses 0,2,4,6,8 while responses drain -> first four returned in order, fifth dropped only if the queue is full at push, overflow=1 in that case.
REQ-038 read16 of address 8, immediately followed by write16 of 0x5555 to address 8 -> response carries the old value; memory then holds 0x5555.
REQ-039 Reset asserted on address cycle 5 of a write16 -> no memory change, rx_pins stays 0, busy=0.
REQ-040 MEM_SERVER_BYTE_WRITE_EN defined, write8 of 0xAB77 to address 2 holding 0x1122 -> memory holds 0x1177; undefined -> unchanged 0x1122.
